// File: rtl/stopwatch_pkg.sv
// Shared encodings, digit limits and time layout for the stopwatch controller.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned TENTHS_MAX   = 9;
  localparam int unsigned SEC_ONES_MAX = 9;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned MIN_ONES_MAX = 9;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } sw_state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
    logic [DIGIT_W-1:0] tenths;
  } sw_time_t;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit: rolls MAX->0 on inc, holds while sat, clr has priority.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               inc,
  input  logic               clr,
  input  logic               sat,
  output logic [DIGIT_W-1:0] digit,
  output logic               at_max
);

  logic [DIGIT_W-1:0] digit_q;

  assign at_max = (digit_q == DIGIT_W'(MAX));
  assign digit  = digit_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digit_q <= '0;
    end else if (clr) begin
      digit_q <= '0;
    end else if (inc && !sat) begin
      digit_q <= at_max ? '0 : digit_q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/stop/lap/reset controller: BCD MM:SS.t accumulator, lap snapshot and display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned MIN_LIMIT = 59,
  parameter bit          WRAP_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_stop_p,
  input  logic                 lap_reset_p,
  input  logic                 tick_100ms,
  output logic                 cnt_enable,
  output logic                 cnt_clear,
  output logic [1:0]           state_o,
  output logic                 lap_active,
  output logic                 overflow_p,
  output logic [DIGIT_W-1:0]   disp_tenths,
  output logic [DIGIT_W-1:0]   disp_sec_ones,
  output logic [DIGIT_W-1:0]   disp_sec_tens,
  output logic [DIGIT_W-1:0]   disp_min_ones,
  output logic [DIGIT_W-1:0]   disp_min_tens
);

  localparam int unsigned      MinTensMax = MIN_LIMIT / 10;
  localparam logic [DIGIT_W-1:0] MinOnesLim = DIGIT_W'(MIN_LIMIT % 10);

  sw_state_e state_q, state_d;
  sw_time_t  time_live, lap_q, lap_d, disp_q;
  logic      lap_active_q, overflow_q, cnt_clear_q;

  logic [DIGIT_W-1:0] t_dig, so_dig, st_dig, mo_dig, mt_dig;
  logic               t_max, so_max, st_max, mo_max, mt_max;
  logic               counting, tick_cnt, at_limit, limit_hit, sat_stop;
  logic               stop_clear, time_clr, sat, lap_capture;
  logic               c_t, c_so, c_st, c_mo;

  assign counting   = (state_q == RUN) || (state_q == LAP);
  assign tick_cnt   = tick_100ms && counting;
  // min_tens never exceeds MIN_LIMIT/10, so its at_max doubles as the limit compare.
  assign at_limit   = t_max && so_max && st_max && mt_max && (mo_dig == MinOnesLim);
  assign limit_hit  = tick_cnt && at_limit;
  assign sat_stop   = limit_hit && !WRAP_EN;
  assign stop_clear = (state_q == STOP) && lap_reset_p && !start_stop_p;
  assign time_clr   = stop_clear || (limit_hit && WRAP_EN);
  assign sat        = at_limit && !WRAP_EN;

  assign c_t  = tick_cnt && t_max;
  assign c_so = c_t && so_max;
  assign c_st = c_so && st_max;
  assign c_mo = c_st && mo_max;

  bcd_digit_counter #(.MAX(TENTHS_MAX)) u_tenths (
    .clk    (clk),
    .resetn (resetn),
    .inc    (tick_cnt),
    .clr    (time_clr),
    .sat    (sat),
    .digit  (t_dig),
    .at_max (t_max)
  );

  bcd_digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk    (clk),
    .resetn (resetn),
    .inc    (c_t),
    .clr    (time_clr),
    .sat    (sat),
    .digit  (so_dig),
    .at_max (so_max)
  );

  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk    (clk),
    .resetn (resetn),
    .inc    (c_so),
    .clr    (time_clr),
    .sat    (sat),
    .digit  (st_dig),
    .at_max (st_max)
  );

  bcd_digit_counter #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .clk    (clk),
    .resetn (resetn),
    .inc    (c_st),
    .clr    (time_clr),
    .sat    (sat),
    .digit  (mo_dig),
    .at_max (mo_max)
  );

  bcd_digit_counter #(.MAX(MinTensMax)) u_min_tens (
    .clk    (clk),
    .resetn (resetn),
    .inc    (c_mo),
    .clr    (time_clr),
    .sat    (sat),
    .digit  (mt_dig),
    .at_max (mt_max)
  );

  assign time_live = {mt_dig, mo_dig, st_dig, so_dig, t_dig};

  // Lap capture uses the pre-edge live time; a forced saturation stop suppresses it.
  assign lap_capture = lap_reset_p && !start_stop_p && counting && !sat_stop;

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    unique case (state_q)
      IDLE: if (start_stop_p) state_d = RUN;
      RUN: begin
        if (start_stop_p)     state_d = STOP;
        else if (lap_reset_p) state_d = LAP;
      end
      LAP:  if (start_stop_p) state_d = STOP;
      STOP: begin
        if (start_stop_p)     state_d = RUN;
        else if (lap_reset_p) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (sat_stop) state_d = STOP;
    if (stop_clear)       lap_d = '0;
    else if (lap_capture) lap_d = time_live;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      lap_q        <= '0;
      disp_q       <= '0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
      cnt_clear_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lap_q        <= lap_d;
      disp_q       <= (state_q == LAP) ? lap_q : time_live;
      lap_active_q <= (state_q == LAP);
      overflow_q   <= limit_hit;
      cnt_clear_q  <= stop_clear;
    end
  end

  assign cnt_enable    = counting;
  assign cnt_clear     = cnt_clear_q;
  assign state_o       = state_q;
  assign lap_active    = lap_active_q;
  assign overflow_p    = overflow_q;
  assign disp_tenths   = disp_q.tenths;
  assign disp_sec_ones = disp_q.sec_ones;
  assign disp_sec_tens = disp_q.sec_tens;
  assign disp_min_ones = disp_q.min_ones;
  assign disp_min_tens = disp_q.min_tens;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: wrapping (index 0) and saturating (index 1) instances vs a tenths-count model.
module tb_stopwatch_ctrl;

  localparam int LIMIT = 59 * 600 + 599;
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_STOP = 3;

  logic clk, resetn, start_stop_p, lap_reset_p, tick_100ms;
  logic       cnt_en_w[2], cnt_clr_w[2], lap_act_w[2], ovf_w[2];
  logic [1:0] state_w[2];
  logic [3:0] dt_w[2], dso_w[2], dst_w[2], dmo_w[2], dmt_w[2];

  int m_state[2], m_time[2], m_lap[2], m_disp[2];
  bit m_lapact[2], m_ovf[2], m_clr[2];
  int passes = 0, total = 0;

  stopwatch_ctrl #(.MIN_LIMIT(59), .WRAP_EN(1'b1)) u_wrap (
    .clk(clk), .resetn(resetn), .start_stop_p(start_stop_p), .lap_reset_p(lap_reset_p),
    .tick_100ms(tick_100ms), .cnt_enable(cnt_en_w[0]), .cnt_clear(cnt_clr_w[0]),
    .state_o(state_w[0]), .lap_active(lap_act_w[0]), .overflow_p(ovf_w[0]),
    .disp_tenths(dt_w[0]), .disp_sec_ones(dso_w[0]), .disp_sec_tens(dst_w[0]),
    .disp_min_ones(dmo_w[0]), .disp_min_tens(dmt_w[0])
  );

  stopwatch_ctrl #(.MIN_LIMIT(59), .WRAP_EN(1'b0)) u_sat (
    .clk(clk), .resetn(resetn), .start_stop_p(start_stop_p), .lap_reset_p(lap_reset_p),
    .tick_100ms(tick_100ms), .cnt_enable(cnt_en_w[1]), .cnt_clear(cnt_clr_w[1]),
    .state_o(state_w[1]), .lap_active(lap_act_w[1]), .overflow_p(ovf_w[1]),
    .disp_tenths(dt_w[1]), .disp_sec_ones(dso_w[1]), .disp_sec_tens(dst_w[1]),
    .disp_min_ones(dmo_w[1]), .disp_min_tens(dmt_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] to_bcd(input int t);
    int m, s;
    m = t / 600;
    s = (t / 10) % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
  endfunction

  function automatic logic [19:0] disp_vec(input int i);
    return {dmt_w[i], dmo_w[i], dst_w[i], dso_w[i], dt_w[i]};
  endfunction

  task automatic check(input string name, input int i, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, i, $time, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = M_IDLE; m_time[i] = 0; m_lap[i] = 0; m_disp[i] = 0;
      m_lapact[i] = 0; m_ovf[i] = 0; m_clr[i] = 0;
    end
  endtask

  task automatic model_update(input int i, input bit ss, input bit lr, input bit tk);
    int st, t, lp, ns;
    bit cnt, hit, sat_stop, clr, wrap;
    wrap = (i == 0);
    st = m_state[i]; t = m_time[i]; lp = m_lap[i];
    cnt = (st == M_RUN) || (st == M_LAP);
    hit = cnt && tk && (t == LIMIT);
    sat_stop = hit && !wrap;
    clr = (st == M_STOP) && lr && !ss;
    m_disp[i] = (st == M_LAP) ? lp : t;
    m_lapact[i] = (st == M_LAP);
    m_ovf[i] = hit;
    m_clr[i] = clr;
    if (clr) m_time[i] = 0;
    else if (cnt && tk) m_time[i] = (t == LIMIT) ? (wrap ? 0 : LIMIT) : t + 1;
    if (clr) m_lap[i] = 0;
    else if (!ss && lr && cnt && !sat_stop) m_lap[i] = t;
    ns = st;
    if (ss) ns = (st == M_IDLE || st == M_STOP) ? M_RUN : M_STOP;
    else if (lr) ns = (st == M_RUN) ? M_LAP : (st == M_STOP) ? M_IDLE : st;
    if (sat_stop) ns = M_STOP;
    m_state[i] = ns;
  endtask

  task automatic check_all(input int i);
    check("state", i, int'(state_w[i]), m_state[i]);
    check("cnt_enable", i, int'(cnt_en_w[i]), int'(m_state[i] == M_RUN || m_state[i] == M_LAP));
    check("cnt_clear", i, int'(cnt_clr_w[i]), int'(m_clr[i]));
    check("lap_active", i, int'(lap_act_w[i]), int'(m_lapact[i]));
    check("overflow_p", i, int'(ovf_w[i]), int'(m_ovf[i]));
    check("display", i, int'(disp_vec(i)), int'(to_bcd(m_disp[i])));
  endtask

  task automatic step(input bit ss, input bit lr, input bit tk);
    start_stop_p = ss; lap_reset_p = lr; tick_100ms = tk;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_update(i, ss, lr, tk);
    @(negedge clk);
    start_stop_p = 0; lap_reset_p = 0; tick_100ms = 0;
    for (int i = 0; i < 2; i++) check_all(i);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1);
  endtask

  // Asserts reset between edges and checks outputs before the next clock edge.
  task automatic do_reset();
    #2 resetn = 0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      check_all(i);
      check("rst_state_lit", i, int'(state_w[i]), 0);
      check("rst_disp_lit", i, int'(disp_vec(i)), 0);
    end
    @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    resetn = 0; start_stop_p = 0; lap_reset_p = 0; tick_100ms = 0;
    @(negedge clk);
    do_reset();

    // 25 ticks then stop
    step(1, 0, 0);
    ticks(25);
    step(1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      check("a_disp_lit", i, int'(disp_vec(i)), 20'h00025);
      check("a_state_lit", i, int'(state_w[i]), 3);
      check("a_cnt_en_lit", i, int'(cnt_en_w[i]), 0);
    end
    ticks(5);
    for (int i = 0; i < 2; i++) check("a_hold_lit", i, int'(disp_vec(i)), 20'h00025);

    // Clear to IDLE, then lap_reset in IDLE is ignored
    step(0, 1, 0);
    for (int i = 0; i < 2; i++) check("clr_lit", i, int'(cnt_clr_w[i]), 1);
    step(0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      check("clr_once_lit", i, int'(cnt_clr_w[i]), 0);
      check("idle_lit", i, int'(state_w[i]), 0);
    end

    // Lap split at 1.2, run on to 4.2
    step(1, 0, 0);
    ticks(12);
    step(0, 1, 0);
    ticks(30);
    for (int i = 0; i < 2; i++) begin
      check("lap_disp_lit", i, int'(disp_vec(i)), 20'h00012);
      check("lap_act_lit", i, int'(lap_act_w[i]), 1);
    end
    step(1, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      check("live_disp_lit", i, int'(disp_vec(i)), 20'h00042);
      check("stop_lit", i, int'(state_w[i]), 3);
    end
    step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 2; i++) check("cleared_lit", i, int'(disp_vec(i)), 0);

    // Simultaneous buttons plus tick at 0.9
    step(1, 0, 0);
    ticks(9);
    step(1, 1, 1);
    step(0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      check("simul_state_lit", i, int'(state_w[i]), 3);
      check("simul_disp_lit", i, int'(disp_vec(i)), 20'h00010);
      check("simul_lapact_lit", i, int'(lap_act_w[i]), 0);
    end

    // Randomized traffic
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 1) == 1);

    // Run to the 59:59.9 limit
    do_reset();
    step(1, 0, 0);
    ticks(LIMIT);
    step(0, 0, 0);
    for (int i = 0; i < 2; i++) check("limit_disp_lit", i, int'(disp_vec(i)), 20'h59599);
    step(0, 0, 1);
    for (int i = 0; i < 2; i++) check("ovf_lit", i, int'(ovf_w[i]), 1);
    check("wrap_state_lit", 0, int'(state_w[0]), 1);
    check("sat_state_lit", 1, int'(state_w[1]), 3);
    step(0, 0, 1);
    check("wrap_disp_lit", 0, int'(disp_vec(0)), 20'h00000);
    check("sat_disp_lit", 1, int'(disp_vec(1)), 20'h59599);
    for (int i = 0; i < 2; i++) check("ovf_once_lit", i, int'(ovf_w[i]), 0);

    // Async reset mid-count at 37.4
    do_reset();
    step(1, 0, 0);
    ticks(374);
    step(0, 0, 0);
    for (int i = 0; i < 2; i++) check("pre_rst_lit", i, int'(disp_vec(i)), 20'h00374);
    do_reset();
    ticks(5);
    step(0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      check("post_rst_disp_lit", i, int'(disp_vec(i)), 0);
      check("post_rst_state_lit", i, int'(state_w[i]), 0);
    end
    step(1, 0, 0);
    ticks(3);
    step(0, 0, 0);
    for (int i = 0; i < 2; i++) check("restart_lit", i, int'(disp_vec(i)), 20'h00003);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
